decode_stage_nw: RTL and testbench
==================================

// Module: decode_stage_nw
// PURPOSE
//  Parametrised N-wide decode stage between IFU and rename. Decodes a fetch bundle of WIDTH
//  slots with per-slot `decoder` instances, checks direct-jump (B/BL) prediction, and
//  redirects fetch on mismatch. Decoded bundles go into a BUF_DEPTH-entry FIFO drained by
//  rename over a valid/ready handshake, so rename back-pressure never loses a bundle.
// PARAMETERS
//  WIDTH      4   slots per bundle (power of 2, 2..8)
//  BUF_DEPTH  2   bundle FIFO entries (>=1)
//  CW         $clog2(WIDTH)  cut-position width (derived)
// PORTS
//  clk             in   1          clock; single clock domain
//  rst_n           in   1          asynchronous active-low reset
//  flush           in   1          backend flush, synchronous, highest priority
//  fetch_valid     in   1          IFU bundle valid
//  fetch_ready     out  1          stage can accept a bundle
//  fetch_instr     in   WIDTH*32   slot i = bits [32i+31:32i]
//  fetch_slot_vld  in   WIDTH      per-slot valid (contiguous from slot 0)
//  fetch_pc        in   32         PC of slot 0
//  pred_taken      in   1          IFU predicted taken in this bundle
//  pred_cut_pos    in   CW         predicted slot index of taken branch
//  pred_target     in   32         predicted next fetch PC
//  redirect_valid  out  1          one-cycle fetch redirect pulse
//  redirect_pc     out  32         corrected fetch PC
//  out_valid       out  1          FIFO head valid
//  out_ready       in   1          rename can accept (freelist check done by rename)
//  out_instrs      out  WIDTH x decoded_instr_t   head bundle decoded slots
//  out_slot_vld    out  WIDTH      head slot valids (after truncation)
//  out_pc          out  32         head bundle fetch_pc
//  out_rd_request  out  CW+1       # valid slots in head with reg_rd_exist
// BEHAVIOUR
//  - Reset/flush: FIFO empty, out_valid=0, out_slot_vld=0, out_pc=0, out_rd_request=0,
//    redirect_valid=0, redirect_pc=0, state=RUN. out_instrs contents don't-care when !out_valid.
//  - fetch_ready = !full && !flush (from registered count). Accept = fetch_valid && fetch_ready.
//  - Decode is combinational on fetch inputs; enqueue on accept; bundle visible at
//    out_valid the cycle after accept (1-cycle latency when FIFO empty).
//  - Jump check over valid slots: j = lowest slot with B/BL; tgt = fetch_pc + 4*j + offset(j).
//    Mispredict A: j exists and (!pred_taken || pred_cut_pos!=j || pred_target!=tgt):
//    redirect_pc=tgt, slots >j cleared in out_slot_vld.
//    Mispredict B: pred_taken and no control-flow instr in valid slots:
//    redirect_pc = fetch_pc + 4*(last valid slot + 1); slots kept.
//    Conditional branches/JIRL are not checked here (resolved in backend).
//  - On accept with mispredict: redirect_valid=1 next cycle (registered), state RUN->DROP.
//    DROP lasts exactly one cycle: fetch_ready=1 regardless of full; any accepted bundle is
//    discarded (no enqueue, no redirect). DROP->RUN unconditionally.
//  - Bundle with fetch_slot_vld==0 is accepted and discarded; no redirect.
//  - Pop on out_valid && out_ready. Push and pop in the same cycle allowed when not full;
//    count unchanged. Pointers wrap modulo BUF_DEPTH; count width holds 0..BUF_DEPTH.
//  - out_rd_request computed at enqueue, stored with bundle; max WIDTH (no overflow).
//  - flush: clears FIFO/state the same edge, discards same-cycle accept, suppresses any
//    pending redirect (redirect_valid=0 next cycle). Async reset may occur mid-bundle;
//    all state returns to reset values immediately.
// TESTING (WIDTH=4, BUF_DEPTH=2)
//  1 Two bundles, out_ready=0 -> 3rd sees fetch_ready=0; raise out_ready -> pop order pc
//    0x1c000000, 0x1c000010; no bundle lost or duplicated.
//  2 pc=0x1c000000, slot1 = B +0x40, pred_taken=0 -> redirect_valid pulse,
//    redirect_pc=0x1c000044, out_slot_vld=4'b0011.
//  3 Same bundle, pred_taken=1, cut=1, target=0x1c000044 -> no redirect, slot_vld=4'b1111.
//  4 pred_taken=1, cut=3, no branches, slot_vld=4'b1111 -> redirect_pc=0x1c000010;
//    bundle presented in next cycle dropped (never at out_valid).
//  5 Slots 0,2 write rd, slot3 rd_exist but slot_vld=4'b0111 -> out_rd_request=2.
//  6 flush in same cycle as mispredicting accept -> FIFO empty, no redirect pulse;
//    rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_stage_nw.sv
// N-wide decode stage: per-slot decode, B/BL prediction check with fetch redirect, bundle FIFO to rename.
// Latency 1 cycle from accept to out_valid (empty FIFO); fetch_ready drops when FIFO full, except in the post-redirect drop cycle.
package decode_stage_nw_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic        reg_rd_exist;
    logic        is_b;
    logic        is_bl;
    logic        is_cf;
    logic [31:0] br_offs;
  } decoded_instr_t;
  localparam int DEC_W = $bits(decoded_instr_t);
endpackage

module decoder import decode_stage_nw_pkg::*; (
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);
  logic [5:0] op;
  logic       is_store;
  logic       is_jirl;

  always_comb begin
    op       = instr[31:26];
    is_store = (instr[31:24] == 8'h29);
    is_jirl  = (op == 6'b010011);
    dec              = '0;
    dec.instr        = instr;
    dec.is_b         = (op == 6'b010100);
    dec.is_bl        = (op == 6'b010101);
    dec.is_cf        = (op >= 6'h10) && (op <= 6'h1b);
    // BL links through r1; other control flow and stores never write a GPR except JIRL
    dec.rd           = dec.is_bl ? 5'd1 : instr[4:0];
    dec.rj           = instr[9:5];
    dec.rk           = instr[14:10];
    dec.reg_rd_exist = dec.is_bl || (is_jirl && instr[4:0] != 5'd0) ||
                       (!dec.is_cf && !is_store && instr[4:0] != 5'd0);
    dec.br_offs      = {{4{instr[9]}}, instr[9:0], instr[25:10], 2'b00};
  end
endmodule

module fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == NW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = nxt(rd_ptr_q);
      cnt_d = cnt_q + NW'(do_push) - NW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module decode_stage_nw import decode_stage_nw_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [WIDTH*32-1:0]    fetch_instr,
  input  logic [WIDTH-1:0]       fetch_slot_vld,
  input  logic [31:0]            fetch_pc,
  input  logic                   pred_taken,
  input  logic [CW-1:0]          pred_cut_pos,
  input  logic [31:0]            pred_target,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*DEC_W-1:0] out_instrs,
  output logic [WIDTH-1:0]       out_slot_vld,
  output logic [31:0]            out_pc,
  output logic [CW:0]            out_rd_request
);
  typedef enum logic {RUN, DROP} state_t;
  typedef struct packed {
    logic [WIDTH*DEC_W-1:0] instrs;
    logic [WIDTH-1:0]       slot_vld;
    logic [31:0]            pc;
    logic [CW:0]            rd_req;
  } entry_t;

  decoded_instr_t         dec [WIDTH];
  logic [WIDTH*DEC_W-1:0] dec_flat;
  logic                   jmp_found, cf_any, mis_a, mis_b;
  logic [CW-1:0]          jmp_idx;
  logic [CW:0]            n_vld, rd_cnt;
  logic [31:0]            jmp_tgt, seq_pc;
  logic [WIDTH-1:0]       keep_vld;
  logic                   accept, push, redir, fifo_full, fifo_empty;
  entry_t                 push_ent, head_ent;
  state_t                 state_q, state_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_slot
    decoder u_dec (.instr(fetch_instr[32*g +: 32]), .dec(dec[g]));
    assign dec_flat[DEC_W*g +: DEC_W] = dec[g];
  end

  always_comb begin
    jmp_found = 1'b0;
    jmp_idx   = '0;
    cf_any    = 1'b0;
    n_vld     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (fetch_slot_vld[i]) begin
        n_vld = n_vld + 1'b1;
        if (dec[i].is_cf) cf_any = 1'b1;
        if ((dec[i].is_b || dec[i].is_bl) && !jmp_found) begin
          jmp_found = 1'b1;
          jmp_idx   = CW'(i);
        end
      end
    end
    jmp_tgt = fetch_pc + {{(30-CW){1'b0}}, jmp_idx, 2'b00} + dec[jmp_idx].br_offs;
    seq_pc  = fetch_pc + {{(29-CW){1'b0}}, n_vld, 2'b00};
    mis_a   = jmp_found && (!pred_taken || pred_cut_pos != jmp_idx || pred_target != jmp_tgt);
    mis_b   = pred_taken && !cf_any && (n_vld != '0);
    // Slots after a mispredicted direct jump are on the wrong path
    keep_vld = '0;
    rd_cnt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      keep_vld[i] = fetch_slot_vld[i] && (!mis_a || CW'(i) <= jmp_idx);
      if (keep_vld[i] && dec[i].reg_rd_exist) rd_cnt = rd_cnt + 1'b1;
    end
  end

  assign fetch_ready = !flush && (state_q == DROP || !fifo_full);
  assign accept      = fetch_valid && fetch_ready;
  assign push        = accept && state_q == RUN && fetch_slot_vld != '0;
  assign redir       = push && (mis_a || mis_b);
  assign push_ent    = '{instrs: dec_flat, slot_vld: keep_vld, pc: fetch_pc, rd_req: rd_cnt};

  fifo #(.DW($bits(entry_t)), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(push), .push_dat(push_ent),
    .pop(out_ready), .pop_dat(head_ent), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    state_d          = RUN;
    redirect_valid_d = redir;
    redirect_pc_d    = redirect_pc_q;
    if (redir) begin
      state_d       = DROP;
      redirect_pc_d = mis_a ? jmp_tgt : seq_pc;
    end
    if (flush) redirect_pc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign out_valid      = !fifo_empty;
  assign out_instrs     = head_ent.instrs;
  assign out_slot_vld   = out_valid ? head_ent.slot_vld : '0;
  assign out_pc         = out_valid ? head_ent.pc : '0;
  assign out_rd_request = out_valid ? head_ent.rd_req : '0;
endmodule

// File: tb/tb_decode_stage_nw.sv
// Scoreboard bench for decode_stage_nw (WIDTH=4, BUF_DEPTH=2): expected bundles/redirects queued at drive time, checked at output.
module tb_decode_stage_nw;
  import decode_stage_nw_pkg::*;

  localparam logic [31:0] NOP   = 32'h0340_0000;
  localparam logic [31:0] B40   = 32'h5000_4000;
  localparam logic [31:0] BL100 = 32'h5401_0000;
  localparam logic [31:0] BEQ   = 32'h5800_0000;
  localparam logic [31:0] ADDI4 = 32'h0280_0004;
  localparam logic [31:0] ADDI5 = 32'h0280_0005;
  localparam logic [31:0] ADDI6 = 32'h0280_0006;
  localparam logic [31:0] STW   = 32'h2980_0064;

  logic                 clk, rst_n, flush, fetch_valid, fetch_ready, pred_taken;
  logic [127:0]         fetch_instr;
  logic [3:0]           fetch_slot_vld, out_slot_vld;
  logic [31:0]          fetch_pc, pred_target, redirect_pc, out_pc;
  logic [1:0]           pred_cut_pos;
  logic                 redirect_valid, out_valid, out_ready;
  logic [4*DEC_W-1:0]   out_instrs;
  logic [2:0]           out_rd_request;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  vld;
    logic [2:0]  rd;
    logic [31:0] i0;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] rq [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  decode_stage_nw #(.WIDTH(4), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_slot_vld(fetch_slot_vld), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_cut_pos(pred_cut_pos), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instrs(out_instrs), .out_slot_vld(out_slot_vld),
    .out_pc(out_pc), .out_rd_request(out_rd_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] bun(input logic [31:0] i0, i1, i2, i3);
    return {i3, i2, i1, i0};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexp_pop", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_slot_vld", 32'(out_slot_vld), 32'(e.vld));
          chk("out_rd_request", 32'(out_rd_request), 32'(e.rd));
          chk("out_instr0", out_instrs[DEC_W-1 -: 32], e.i0);
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) chk("unexp_redir", 32'(rq.size()), 32'd1);
        else chk("redirect_pc", redirect_pc, rq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] pc, input logic [127:0] ins, input logic [3:0] vld,
                      input logic tk, input logic [1:0] cut, input logic [31:0] tgt,
                      input logic exp_push, input logic [3:0] exp_vld, input logic [2:0] exp_rd,
                      input logic exp_redir, input logic [31:0] exp_rpc);
    fetch_pc = pc; fetch_instr = ins; fetch_slot_vld = vld;
    pred_taken = tk; pred_cut_pos = cut; pred_target = tgt; fetch_valid = 1'b1;
    for (int i = 0; i < 50 && !fetch_ready; i++) begin @(posedge clk); #1; end
    if (!fetch_ready) begin
      chk("ready_timeout", 32'(fetch_ready), 32'd1);
      fetch_valid = 1'b0;
      return;
    end
    if (exp_push) sb.push_back('{pc, exp_vld, exp_rd, ins[31:0]});
    if (exp_redir) rq.push_back(exp_rpc);
    @(posedge clk); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || rq.size() != 0); i++) begin @(posedge clk); #1; end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_rq", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
    fetch_instr = '0; fetch_slot_vld = '0; fetch_pc = '0;
    pred_taken = 1'b0; pred_cut_pos = '0; pred_target = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_slot_vld", 32'(out_slot_vld), 32'd0);
    chk("rst_out_rd", 32'(out_rd_request), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(1);

    // Backpressure: two bundles fill the FIFO, third is refused until rename drains
    send(32'h1c00_0000, bun(NOP, NOP, NOP, NOP), 4'hF, 0, 0, 0, 1, 4'hF, 0, 0, 0);
    send(32'h1c00_0010, bun(ADDI4, NOP, NOP, NOP), 4'hF, 0, 0, 0, 1, 4'hF, 1, 0, 0);
    fetch_pc = 32'h1c00_0020; fetch_slot_vld = 4'hF; fetch_valid = 1'b1;
    chk("full_ready0", 32'(fetch_ready), 32'd0);
    idle(1);
    chk("full_ready1", 32'(fetch_ready), 32'd0);
    fetch_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Direct-jump checks
    send(32'h1c00_0000, bun(NOP, B40, NOP, NOP), 4'hF, 0, 0, 0, 1, 4'b0011, 0, 1, 32'h1c00_0044);
    idle(1);
    send(32'h1c00_0000, bun(NOP, B40, NOP, NOP), 4'hF, 1, 1, 32'h1c00_0044, 1, 4'hF, 0, 0, 0);
    idle(1);
    send(32'h1c00_0000, bun(NOP, B40, NOP, NOP), 4'hF, 1, 1, 32'h1c00_0048, 1, 4'b0011, 0, 1, 32'h1c00_0044);
    idle(1);
    send(32'h1c00_0000, bun(NOP, B40, NOP, NOP), 4'hF, 1, 2, 32'h1c00_0044, 1, 4'b0011, 0, 1, 32'h1c00_0044);
    idle(1);
    send(32'h1c00_0080, bun(BL100, NOP, NOP, NOP), 4'hF, 1, 0, 32'h1c00_0180, 1, 4'hF, 1, 0, 0);
    idle(1);
    send(32'h1c00_00c0, bun(NOP, BEQ, NOP, NOP), 4'hF, 1, 1, 32'h1c00_0000, 1, 4'hF, 0, 0, 0);
    idle(1);
    send(32'h1c00_00e0, bun(NOP, NOP, B40, NOP), 4'b0011, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
    idle(1);
    drain();

    // Predicted taken without control flow; following bundle lands in the drop cycle
    send(32'h1c00_0000, bun(NOP, NOP, NOP, NOP), 4'hF, 1, 3, 32'h1c00_0100, 1, 4'hF, 0, 1, 32'h1c00_0010);
    send(32'h1c00_0100, bun(ADDI5, NOP, NOP, NOP), 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    send(32'h1c00_0020, bun(NOP, NOP, NOP, NOP), 4'b0011, 1, 1, 32'h1c00_0300, 1, 4'b0011, 0, 1, 32'h1c00_0028);
    idle(1);
    send(32'h1c00_0040, bun(ADDI4, STW, ADDI5, ADDI6), 4'b0111, 0, 0, 0, 1, 4'b0111, 2, 0, 0);
    send(32'h1c00_0060, bun(ADDI4, ADDI5, NOP, NOP), 4'b0000, 1, 0, 32'h1c00_0000, 0, 0, 0, 0, 0);
    idle(1);
    drain();

    // Flush together with a mispredicting bundle
    out_ready = 1'b0;
    send(32'h1c00_0200, bun(NOP, NOP, NOP, NOP), 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    fetch_pc = 32'h1c00_0300; fetch_instr = bun(B40, NOP, NOP, NOP); fetch_slot_vld = 4'hF;
    pred_taken = 1'b0; fetch_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_ready", 32'(fetch_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_pc", out_pc, 32'd0);
    chk("flush_redirect", 32'(redirect_valid), 32'd0);
    idle(1);
    chk("flush_redirect2", 32'(redirect_valid), 32'd0);
    chk("flush_out_valid2", 32'(out_valid), 32'd0);

    // Async reset while a bundle is held and a redirect is in flight
    send(32'h1c00_0200, bun(B40, NOP, NOP, NOP), 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    chk("mid_redirect", 32'(redirect_valid), 32'd1);
    chk("mid_redirect_pc", redirect_pc, 32'h1c00_0240);
    chk("mid_slot_vld", 32'(out_slot_vld), 32'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_redirect", 32'(redirect_valid), 32'd0);
    chk("arst_redirect_pc", redirect_pc, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_slot_vld", 32'(out_slot_vld), 32'd0);
    chk("arst_rd", 32'(out_rd_request), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    send(32'h1c00_0400, bun(ADDI6, NOP, ADDI4, NOP), 4'hF, 0, 0, 0, 1, 4'hF, 2, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
